// File: rtl/sram_param_pkg.sv
// Shared types and lane-mask helpers for the parametrised 1rwNr SRAM model.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package sram_param_pkg;

  // Upper bounds for the width-generic helpers; callers zero-extend into these
  // and slice the low DATA_WIDTH bits back out.
  localparam int MAX_DATA_WIDTH = 256;
  localparam int MAX_WMASKS     = 256;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // One enable bit per data bit: bit b follows lane b/lane_w of the mask.
  function automatic logic [MAX_DATA_WIDTH-1:0] expand_wmask(
    input logic [MAX_WMASKS-1:0] mask,
    input int unsigned           lane_w
  );
    logic [MAX_DATA_WIDTH-1:0] en;
    int unsigned               lane;
    en = '0;
    for (int b = 0; b < MAX_DATA_WIDTH; b++) begin
      lane  = b / lane_w;
      en[b] = mask[lane[7:0]];
    end
    return en;
  endfunction

  // Masked lanes take the new data, unmasked lanes keep the old contents.
  // The same merge produces both the stored word and the forwarded read word.
  function automatic logic [MAX_DATA_WIDTH-1:0] merge_lanes(
    input logic [MAX_DATA_WIDTH-1:0] old_w,
    input logic [MAX_DATA_WIDTH-1:0] new_w,
    input logic [MAX_WMASKS-1:0]     mask,
    input int unsigned               lane_w
  );
    logic [MAX_DATA_WIDTH-1:0] en;
    en = expand_wmask(mask, lane_w);
    return (old_w & ~en) | (new_w & en);
  endfunction

endpackage

// File: rtl/sram_read_pipe.sv
// Per-port read pipeline carrying valid, data and collision flag.
// Latency: READ_LATENCY edges from the accepting edge (stage 0 captures at acceptance).
// Backpressure: none; accepts one read per cycle, data holds between strobes.
module sram_read_pipe
  import sram_param_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  i_rd_vld,
  input  logic [DATA_WIDTH-1:0] i_rd_dat,
  input  logic                  i_rd_col,
  output logic                  o_rd_vld,
  output logic [DATA_WIDTH-1:0] o_rd_dat,
  output logic                  o_rd_col
);

  logic [READ_LATENCY-1:0] r_vld;
  logic [READ_LATENCY-1:0] r_col;
  logic [DATA_WIDTH-1:0]   r_dat [READ_LATENCY];

  // Shift strobes every cycle; data stages only load behind a valid so the
  // output holds its last read value between strobes.
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      r_vld <= '0;
      r_col <= '0;
      for (int k = 0; k < READ_LATENCY; k++) r_dat[k] <= '0;
    end else begin
      r_vld[0] <= i_rd_vld;
      r_col[0] <= i_rd_vld & i_rd_col;
      if (i_rd_vld) r_dat[0] <= i_rd_dat;
      for (int k = 1; k < READ_LATENCY; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_col[k] <= r_col[k-1];
        if (r_vld[k-1]) r_dat[k] <= r_dat[k-1];
      end
    end
  end

  assign o_rd_vld = r_vld[READ_LATENCY-1];
  assign o_rd_col = r_col[READ_LATENCY-1];
  assign o_rd_dat = r_dat[READ_LATENCY-1];

endmodule

// File: rtl/sram_1rwnr_param.sv
// Parametrised 1rw + NUM_RPORTS-r SRAM model with optional zero-fill after reset.
// Latency: READ_LATENCY edges per read on every port; writes land on the accepting edge.
// Backpressure: ready low during reset/CLEAR, requests then dropped; otherwise one op per port per cycle.
module sram_1rwnr_param
  import sram_param_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 9,
  parameter int WMASK_WIDTH  = 8,
  parameter int NUM_RPORTS   = 1,
  parameter int READ_LATENCY = 1,
  parameter int INIT_CLEAR   = 1
) (
  input  logic                             clk0,
  input  logic                             rst0,
  output logic                             ready,
  input  logic                             csb0,
  input  logic                             web0,
  input  logic [DATA_WIDTH/WMASK_WIDTH-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]            addr0,
  input  logic [DATA_WIDTH-1:0]            din0,
  output logic [DATA_WIDTH-1:0]            dout0,
  output logic                             dout0_valid,
  input  logic [NUM_RPORTS-1:0]            csb_r,
  input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] addr_r,
  output logic [NUM_RPORTS*DATA_WIDTH-1:0] dout_r,
  output logic [NUM_RPORTS-1:0]            dout_r_valid,
  output logic [NUM_RPORTS-1:0]            collision
);

  localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;
  localparam int NUM_WMASKS = DATA_WIDTH / WMASK_WIDTH;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_clr_cnt;
  logic                    r_ready;
  logic [DATA_WIDTH-1:0]   r_mem [RAM_DEPTH];

  logic                      w_wr_acc;
  logic                      w_rd0_acc;
  logic [MAX_WMASKS-1:0]     w_mask_ext;
  logic [MAX_DATA_WIDTH-1:0] w_old_ext;
  logic [MAX_DATA_WIDTH-1:0] w_din_ext;
  logic [MAX_DATA_WIDTH-1:0] w_merge_wide;
  logic [DATA_WIDTH-1:0]     w_wr_dat;
  logic                      w_unused_col0;

  assign ready     = r_ready;
  assign w_wr_acc  = r_ready & ~csb0 & ~web0;
  assign w_rd0_acc = r_ready & ~csb0 &  web0;

  // Clear sequencer: walk the counter over every word, then open for requests.
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      r_state   <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;
      r_clr_cnt <= '0;
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_ready <= 1'b0;
          if (r_clr_cnt == {ADDR_WIDTH{1'b1}}) begin
            r_state <= ST_READY;
            r_ready <= 1'b1;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        default: r_ready <= 1'b1;
      endcase
    end
  end

  // Lane-merged write word; also the forwarded value for same-address reads.
  always_comb begin
    w_mask_ext                   = '0;
    w_mask_ext[NUM_WMASKS-1:0]   = wmask0;
    w_old_ext                    = '0;
    w_old_ext[DATA_WIDTH-1:0]    = r_mem[addr0];
    w_din_ext                    = '0;
    w_din_ext[DATA_WIDTH-1:0]    = din0;
    w_merge_wide                 = merge_lanes(w_old_ext, w_din_ext, w_mask_ext, WMASK_WIDTH);
    w_wr_dat                     = w_merge_wide[DATA_WIDTH-1:0];
  end

  // Array update: zero fill while clearing, masked port-0 write once ready.
  // No reset here so contents survive reset when INIT_CLEAR is 0.
  always_ff @(posedge clk0) begin
    if (r_state == ST_CLEAR) r_mem[r_clr_cnt] <= '0;
    else if (w_wr_acc)       r_mem[addr0]     <= w_wr_dat;
  end

  sram_read_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_pipe0 (
    .clk0    (clk0),
    .rst0    (rst0),
    .i_rd_vld(w_rd0_acc),
    .i_rd_dat(r_mem[addr0]),
    .i_rd_col(1'b0),
    .o_rd_vld(dout0_valid),
    .o_rd_dat(dout0),
    .o_rd_col(w_unused_col0)
  );

  for (genvar r = 0; r < NUM_RPORTS; r++) begin : g_rport
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_acc;
    logic                  w_col;
    logic [DATA_WIDTH-1:0] w_dat;

    assign w_addr = addr_r[r*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_acc  = r_ready & ~csb_r[r];
    assign w_col  = w_acc & w_wr_acc & (w_addr == addr0);
    // Write-first: on a collision the addresses match, so the merged write word is the answer.
    assign w_dat  = w_col ? w_wr_dat : r_mem[w_addr];

    sram_read_pipe #(
      .DATA_WIDTH  (DATA_WIDTH),
      .READ_LATENCY(READ_LATENCY)
    ) u_pipe (
      .clk0    (clk0),
      .rst0    (rst0),
      .i_rd_vld(w_acc),
      .i_rd_dat(w_dat),
      .i_rd_col(w_col),
      .o_rd_vld(dout_r_valid[r]),
      .o_rd_dat(dout_r[r*DATA_WIDTH +: DATA_WIDTH]),
      .o_rd_col(collision[r])
    );
  end

endmodule

// File: tb/tb_sram_1rwnr_param.sv
// Directed bench: three instances (latency 1 with clear, latency 2 with clear, no clear)
// sharing one request bus; vectors applied from a table, corner cases hand-sequenced.
module tb_sram_1rwnr_param;

  logic        clk = 1'b0;
  logic        rst_ab, rst_c;
  logic        csb0, web0;
  logic [3:0]  wmask0;
  logic [8:0]  addr0;
  logic [31:0] din0;
  logic [1:0]  csb_r;
  logic [17:0] addr_r;

  logic        a_ready, b_ready, c_ready;
  logic [31:0] a_dout0, b_dout0, c_dout0;
  logic        a_v0, b_v0, c_v0;
  logic [63:0] a_dr, b_dr, c_dr;
  logic [1:0]  a_vr, b_vr, c_vr;
  logic [1:0]  a_col, b_col, c_col;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sram_1rwnr_param #(.NUM_RPORTS(2), .READ_LATENCY(1), .INIT_CLEAR(1)) dut_a (
    .clk0(clk), .rst0(rst_ab), .ready(a_ready), .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .din0(din0), .dout0(a_dout0), .dout0_valid(a_v0), .csb_r(csb_r),
    .addr_r(addr_r), .dout_r(a_dr), .dout_r_valid(a_vr), .collision(a_col));

  sram_1rwnr_param #(.NUM_RPORTS(2), .READ_LATENCY(2), .INIT_CLEAR(1)) dut_b (
    .clk0(clk), .rst0(rst_ab), .ready(b_ready), .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .din0(din0), .dout0(b_dout0), .dout0_valid(b_v0), .csb_r(csb_r),
    .addr_r(addr_r), .dout_r(b_dr), .dout_r_valid(b_vr), .collision(b_col));

  sram_1rwnr_param #(.NUM_RPORTS(2), .READ_LATENCY(1), .INIT_CLEAR(0)) dut_c (
    .clk0(clk), .rst0(rst_c), .ready(c_ready), .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .din0(din0), .dout0(c_dout0), .dout0_valid(c_v0), .csb_r(csb_r),
    .addr_r(addr_r), .dout_r(c_dr), .dout_r_valid(c_vr), .collision(c_col));

  typedef struct {
    logic        csb0;
    logic        web0;
    logic [3:0]  wm;
    logic [8:0]  a0;
    logic [31:0] d0;
    logic [1:0]  csbr;
    logic [8:0]  ar0;
    logic [8:0]  ar1;
    logic        ev0;
    logic [31:0] ed0;
    logic [1:0]  evr;
    logic [31:0] edr0;
    logic [31:0] edr1;
    logic [1:0]  ecol;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    csb0 = 1'b1; web0 = 1'b1; wmask0 = 4'h0; addr0 = '0; din0 = '0;
    csb_r = 2'b11; addr_r = '0;
  endtask

  task automatic drive_read(input logic [8:0] a);
    csb0 = 1'b0; web0 = 1'b1; addr0 = a; csb_r = 2'b00; addr_r = {a, a};
  endtask

  task automatic check_vec(input string tag, input vec_t v, input logic v0, input logic [31:0] d0,
                           input logic [1:0] vr, input logic [63:0] dr, input logic [1:0] col);
    chk({tag, " v0"}, v0, v.ev0);
    if (v.ev0) chk({tag, " d0"}, d0, v.ed0);
    chk({tag, " vr"}, vr, v.evr);
    if (v.evr[0]) chk({tag, " dr0"}, dr[31:0], v.edr0);
    if (v.evr[1]) chk({tag, " dr1"}, dr[63:32], v.edr1);
    chk({tag, " col"}, col, v.ecol);
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!a_ready && n < 1000);
    chk({tag, " a_ready_cycles"}, n, 512);
    chk({tag, " b_ready"}, b_ready, 1'b1);
  endtask

  logic [31:0] bb_val[4];
  int          bad;

  initial begin
    //          csb0 web0 wm     a0  d0            csbr   ar0 ar1 ev0 ed0           evr    edr0          edr1          ecol
    vecs[0]  = '{1'b0, 1'b1, 4'h0, 9'd5, 32'h0,         2'b00, 9'd5, 9'd5, 1'b1, 32'h0,         2'b11, 32'h0,         32'h0,         2'b00};
    vecs[1]  = '{1'b0, 1'b0, 4'hF, 9'd3, 32'h11223344,  2'b11, 9'd0, 9'd0, 1'b0, 32'h0,         2'b00, 32'h0,         32'h0,         2'b00};
    vecs[2]  = '{1'b0, 1'b0, 4'h5, 9'd3, 32'hAABBCCDD,  2'b11, 9'd0, 9'd0, 1'b0, 32'h0,         2'b00, 32'h0,         32'h0,         2'b00};
    vecs[3]  = '{1'b0, 1'b1, 4'h0, 9'd3, 32'h0,         2'b10, 9'd3, 9'd0, 1'b1, 32'h11BB33DD,  2'b01, 32'h11BB33DD,  32'h0,         2'b00};
    vecs[4]  = '{1'b0, 1'b0, 4'hF, 9'd7, 32'h12345678,  2'b11, 9'd0, 9'd0, 1'b0, 32'h0,         2'b00, 32'h0,         32'h0,         2'b00};
    vecs[5]  = '{1'b0, 1'b0, 4'h3, 9'd7, 32'hFFFFFFFF,  2'b00, 9'd7, 9'd8, 1'b0, 32'h0,         2'b11, 32'h1234FFFF,  32'h0,         2'b01};
    vecs[6]  = '{1'b0, 1'b1, 4'h0, 9'd7, 32'h0,         2'b01, 9'd0, 9'd7, 1'b1, 32'h1234FFFF,  2'b10, 32'h0,         32'h1234FFFF,  2'b00};
    vecs[7]  = '{1'b0, 1'b0, 4'h0, 9'd7, 32'hDEADBEEF,  2'b00, 9'd9, 9'd7, 1'b0, 32'h0,         2'b11, 32'h0,         32'h1234FFFF,  2'b10};
    vecs[8]  = '{1'b0, 1'b0, 4'hF, 9'd0, 32'h0000A000,  2'b11, 9'd0, 9'd0, 1'b0, 32'h0,         2'b00, 32'h0,         32'h0,         2'b00};
    vecs[9]  = '{1'b0, 1'b0, 4'hF, 9'd1, 32'h0000A001,  2'b11, 9'd0, 9'd0, 1'b0, 32'h0,         2'b00, 32'h0,         32'h0,         2'b00};
    vecs[10] = '{1'b0, 1'b0, 4'hF, 9'd2, 32'h0000A002,  2'b11, 9'd0, 9'd0, 1'b0, 32'h0,         2'b00, 32'h0,         32'h0,         2'b00};
    vecs[11] = '{1'b1, 1'b0, 4'hF, 9'd3, 32'h0,         2'b10, 9'd3, 9'd0, 1'b0, 32'h0,         2'b01, 32'h11BB33DD,  32'h0,         2'b00};
    vecs[12] = '{1'b0, 1'b1, 4'h0, 9'd3, 32'h0,         2'b11, 9'd0, 9'd0, 1'b1, 32'h11BB33DD,  2'b00, 32'h0,         32'h0,         2'b00};
    bb_val[0] = 32'h0000A000; bb_val[1] = 32'h0000A001;
    bb_val[2] = 32'h0000A002; bb_val[3] = 32'h11BB33DD;

    idle();
    rst_ab = 1'b1;
    rst_c  = 1'b1;
    #12;
    chk("rst a_ready", a_ready, 1'b0);
    chk("rst a_dout0", a_dout0, 32'h0);
    chk("rst a_v0", a_v0, 1'b0);
    chk("rst a_dout_r", a_dr, 64'h0);
    chk("rst a_vr", a_vr, 2'b00);
    chk("rst a_col", a_col, 2'b00);
    chk("rst b_ready", b_ready, 1'b0);
    chk("rst c_ready", c_ready, 1'b0);

    // No-clear instance: ready straight after release, contents survive reset.
    @(posedge clk); #1;
    rst_c = 1'b0;
    @(posedge clk); #1;
    chk("c ready after release", c_ready, 1'b1);
    csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF; addr0 = 9'd9; din0 = 32'hCAFEF00D;
    @(posedge clk); #1;
    idle();
    rst_c = 1'b1;
    #2;
    chk("c ready in reset", c_ready, 1'b0);
    chk("c dout0 in reset", c_dout0, 32'h0);
    @(posedge clk); #1;
    rst_c = 1'b0;
    @(posedge clk); #1;
    chk("c ready first cycle", c_ready, 1'b1);
    drive_read(9'd9);
    @(posedge clk); #1;
    idle();
    chk("c v0 retained", c_v0, 1'b1);
    chk("c dout0 retained", c_dout0, 32'hCAFEF00D);
    chk("c dr0 retained", c_dr[31:0], 32'hCAFEF00D);

    // Clear in progress: requests dropped, reset at counter 100 restarts the clear.
    @(posedge clk); #1;
    rst_ab = 1'b0;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      drive_read(9'd5);
      @(posedge clk); #1;
      if (a_v0 || b_v0 || a_vr != 2'b00 || b_vr != 2'b00 || a_ready) bad++;
    end
    idle();
    chk("clear requests dropped", bad, 0);
    rst_ab = 1'b1;
    #2;
    chk("midclear reset ready", a_ready, 1'b0);
    @(posedge clk); #1;
    rst_ab = 1'b0;
    wait_ready("clear restart");

    // Table-driven vectors: latency-1 checked one edge after issue, latency-2 one edge later.
    for (int i = 0; i < 13; i++) begin
      csb0 = vecs[i].csb0; web0 = vecs[i].web0; wmask0 = vecs[i].wm;
      addr0 = vecs[i].a0; din0 = vecs[i].d0; csb_r = vecs[i].csbr;
      addr_r = {vecs[i].ar1, vecs[i].ar0};
      @(posedge clk); #1;
      idle();
      check_vec($sformatf("v%0d a", i), vecs[i], a_v0, a_dout0, a_vr, a_dr, a_col);
      if (vecs[i].ev0 == 1'b0) chk($sformatf("v%0d b early v0", i), b_v0, 1'b0);
      @(posedge clk); #1;
      check_vec($sformatf("v%0d b", i), vecs[i], b_v0, b_dout0, b_vr, b_dr, b_col);
      chk($sformatf("v%0d a strobe", i), a_v0, 1'b0);
    end

    // Back-to-back reads of addresses 0..3 on every port.
    for (int c = 0; c < 6; c++) begin
      if (c < 4) drive_read(c[8:0]);
      else idle();
      @(posedge clk); #1;
      chk($sformatf("bb%0d a v0", c), a_v0, (c < 4));
      chk($sformatf("bb%0d a vr", c), a_vr, (c < 4) ? 2'b11 : 2'b00);
      if (c < 4) begin
        chk($sformatf("bb%0d a d0", c), a_dout0, bb_val[c]);
        chk($sformatf("bb%0d a dr", c), a_dr, {bb_val[c], bb_val[c]});
      end
      chk($sformatf("bb%0d b v0", c), b_v0, (c >= 1 && c <= 4));
      chk($sformatf("bb%0d b vr", c), b_vr, (c >= 1 && c <= 4) ? 2'b11 : 2'b00);
      if (c >= 1 && c <= 4) begin
        chk($sformatf("bb%0d b d0", c), b_dout0, bb_val[c-1]);
        chk($sformatf("bb%0d b dr", c), b_dr, {bb_val[c-1], bb_val[c-1]});
      end
    end
    idle();

    // Reset with a latency-2 read in flight: it must never emerge.
    drive_read(9'd3);
    @(posedge clk); #1;
    idle();
    rst_ab = 1'b1;
    #2;
    chk("flight b_ready", b_ready, 1'b0);
    chk("flight b_v0", b_v0, 1'b0);
    chk("flight b_dout0", b_dout0, 32'h0);
    @(posedge clk); #1;
    chk("flight b_v0 after edge", b_v0, 1'b0);
    chk("flight b_vr after edge", b_vr, 2'b00);
    rst_ab = 1'b0;
    wait_ready("pipe reset");

    // Re-clear zeroed previously written words.
    drive_read(9'd3);
    @(posedge clk); #1;
    idle();
    chk("recleared v0", a_v0, 1'b1);
    chk("recleared d0", a_dout0, 32'h0);
    @(posedge clk); #1;
    chk("recleared b d0", b_dout0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
